proc_sequencer: RTL and testbench

Multi-cycle control FSM for the single-issue core.
- Fetches an instruction word from instruction memory over a req/ack handshake and holds it in an instruction register (IR).
- Presents the IR to the decoder, waits out the ALU latency, then issues a single-cycle register-file write strobe.
- Advances the PC, and traps on illegal opcodes or memory timeout.

---
 rtl/proc_sequencer_pkg.sv | 42 ++++
 rtl/proc_sequencer_timer.sv | 40 ++++
 rtl/proc_sequencer.sv | 155 +++++++++++++++
 tb/tb_proc_sequencer.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// proc_sequencer_pkg : decoder opcode constants plus sequencer encodings
// Revision 1.0
// ============================================================================
package proc_sequencer_pkg;

    // Opcode field ir[27:24] and fn field ir[31:28] values shared with the decoder
    localparam logic [3:0] OP_ALUR  = 4'b0000;
    localparam logic [3:0] OP_ALUI  = 4'b1000;
    localparam logic [3:0] OP_CMPR  = 4'b0010;
    localparam logic [3:0] OP_CMPI  = 4'b1010;
    localparam logic [3:0] OP_BCOND = 4'b0110;
    localparam logic [3:0] OP_SW    = 4'b0101;
    localparam logic [3:0] OP_LW    = 4'b1001;
    localparam logic [3:0] OP_JAL   = 4'b1011;
    localparam logic [3:0] FN_ADD   = 4'b0000;
    localparam logic [3:0] FN_SUB   = 4'b0001;

    typedef enum logic [2:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_FETCH  = 3'd1,
        SEQ_DECODE = 3'd2,
        SEQ_EXEC   = 3'd3,
        SEQ_WB     = 3'd4,
        SEQ_HALT   = 3'd5,
        SEQ_TRAP   = 3'd6
    } seq_state_e;

    localparam logic [1:0] TRAP_NONE    = 2'd0;
    localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
    localparam logic [1:0] TRAP_TIMEOUT = 2'd2;

    localparam int unsigned PC_STEP = 4;

    // Only the ALU/compare classes are executed by this sequencer
    function automatic logic is_legal_op(input logic [3:0] op);
        return op inside {OP_ALUR, OP_ALUI, OP_CMPR, OP_CMPI};
    endfunction

endpackage
`default_nettype wire

// File: rtl/proc_sequencer_timer.sv
`default_nettype none
// ============================================================================
// seq_timer : loadable down-counter, tc high while the count is zero
// Revision 1.0
// ============================================================================
module seq_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             tc
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/proc_sequencer.sv
`default_nettype none
// ============================================================================
// proc_sequencer : multi-cycle fetch/decode/exec/writeback control FSM
// Revision 1.0
// ============================================================================
module proc_sequencer
    import proc_sequencer_pkg::*;
#(
    parameter int                   WORD_SIZE    = 32,
    parameter logic [WORD_SIZE-1:0] RESET_PC     = '0,
    parameter int                   ALU_LATENCY  = 1,
    parameter int                   IMEM_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic                 halt_req,
    output logic                 imem_req,
    output logic [WORD_SIZE-1:0] imem_addr,
    input  logic                 imem_ack,
    input  logic [WORD_SIZE-1:0] imem_rdata,
    output logic [WORD_SIZE-1:0] ir,
    input  logic                 dec_wrtEn,
    output logic                 rf_wrtEn,
    output logic [WORD_SIZE-1:0] pc,
    output logic [2:0]           state,
    output logic                 halted,
    output logic                 trap,
    output logic [1:0]           trap_cause,
    output logic [15:0]          retired
);

    // Timer stops at zero, so loading N-1 gives exactly N cycles in the state
    localparam logic [7:0] TMO_LOAD = 8'(IMEM_TIMEOUT - 1);
    localparam logic [7:0] LAT_LOAD = 8'(ALU_LATENCY - 1);

    seq_state_e           state_q, state_d;
    logic [WORD_SIZE-1:0] pc_q, pc_d;
    logic [WORD_SIZE-1:0] ir_q, ir_d;
    logic [15:0]          retired_q, retired_d;
    logic [1:0]           cause_q, cause_d;
    logic                 tmr_load, tmr_dec, tmr_tc;
    logic [7:0]           tmr_val;

    seq_timer #(.WIDTH(8)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .tc       (tmr_tc)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        cause_d   = cause_q;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        tmr_dec   = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                if (run) begin
                    state_d  = SEQ_FETCH;
                    tmr_load = 1'b1;
                    tmr_val  = TMO_LOAD;
                end
            end
            SEQ_FETCH: begin
                if (imem_ack) begin
                    ir_d     = imem_rdata;
                    state_d  = SEQ_DECODE;
                    tmr_load = 1'b1;
                end else if (tmr_tc) begin
                    cause_d = TRAP_TIMEOUT;
                    state_d = SEQ_TRAP;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            SEQ_DECODE: begin
                if (is_legal_op(ir_q[27:24])) begin
                    state_d  = SEQ_EXEC;
                    tmr_load = 1'b1;
                    tmr_val  = LAT_LOAD;
                end else begin
                    cause_d = TRAP_ILLEGAL;
                    state_d = SEQ_TRAP;
                end
            end
            SEQ_EXEC: begin
                if (tmr_tc) begin
                    state_d = SEQ_WB;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            SEQ_WB: begin
                pc_d      = pc_q + WORD_SIZE'(PC_STEP);
                retired_d = retired_q + 16'd1;
                if (halt_req || !run) begin
                    state_d = SEQ_HALT;
                end else begin
                    state_d  = SEQ_FETCH;
                    tmr_load = 1'b1;
                    tmr_val  = TMO_LOAD;
                end
            end
            SEQ_HALT: begin
                if (run && !halt_req) begin
                    state_d  = SEQ_FETCH;
                    tmr_load = 1'b1;
                    tmr_val  = TMO_LOAD;
                end
            end
            SEQ_TRAP: begin
                state_d = SEQ_TRAP;
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SEQ_IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            retired_q <= '0;
            cause_q   <= TRAP_NONE;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
            cause_q   <= cause_d;
        end
    end

    assign imem_req   = (state_q == SEQ_FETCH);
    assign imem_addr  = pc_q;
    assign ir         = ir_q;
    assign rf_wrtEn   = (state_q == SEQ_WB) && dec_wrtEn;
    assign pc         = pc_q;
    assign state      = state_q;
    assign halted     = (state_q == SEQ_HALT);
    assign trap       = (state_q == SEQ_TRAP);
    assign trap_cause = cause_q;
    assign retired    = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_proc_sequencer.sv
`default_nettype none
// ============================================================================
// tb_proc_sequencer : randomized scoreboard bench for proc_sequencer
// Revision 1.0
// ============================================================================
module tb_proc_sequencer;

    localparam int          ALU_LAT  = 3;
    localparam int          TMO      = 8;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;
    localparam logic [31:0] RST_PC_B = 32'hFFFF_FFFC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Main instance
    logic        rst_n = 1'b1, run = 1'b0, halt_req = 1'b0, imem_ack = 1'b0, dec_wrtEn = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req, rf_wrtEn, halted, trap;
    logic [31:0] imem_addr, ir, pc;
    logic [2:0]  state;
    logic [1:0]  trap_cause;
    logic [15:0] retired;

    proc_sequencer #(
        .WORD_SIZE(32), .RESET_PC(RST_PC), .ALU_LATENCY(ALU_LAT), .IMEM_TIMEOUT(TMO)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .run(run), .halt_req(halt_req),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ir(ir), .dec_wrtEn(dec_wrtEn), .rf_wrtEn(rf_wrtEn), .pc(pc), .state(state),
        .halted(halted), .trap(trap), .trap_cause(trap_cause), .retired(retired)
    );

    // Second instance: single-cycle ALU and a reset PC at the top of memory
    logic        b_rst_n = 1'b1, b_run = 1'b0, b_halt_req = 1'b0, b_imem_ack = 1'b0, b_dec_wrtEn = 1'b0;
    logic [31:0] b_imem_rdata = '0;
    logic        b_imem_req, b_rf_wrtEn, b_halted, b_trap;
    logic [31:0] b_imem_addr, b_ir, b_pc;
    logic [2:0]  b_state;
    logic [1:0]  b_trap_cause;
    logic [15:0] b_retired;
    bit          b_done = 0;

    proc_sequencer #(
        .WORD_SIZE(32), .RESET_PC(RST_PC_B), .ALU_LATENCY(1), .IMEM_TIMEOUT(255)
    ) u_dut_b (
        .clk(clk), .rst_n(b_rst_n), .run(b_run), .halt_req(b_halt_req),
        .imem_req(b_imem_req), .imem_addr(b_imem_addr), .imem_ack(b_imem_ack), .imem_rdata(b_imem_rdata),
        .ir(b_ir), .dec_wrtEn(b_dec_wrtEn), .rf_wrtEn(b_rf_wrtEn), .pc(b_pc), .state(b_state),
        .halted(b_halted), .trap(b_trap), .trap_cause(b_trap_cause), .retired(b_retired)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: architectural PC / retire count plus expected DUT events
    typedef struct {
        bit          is_trap;
        logic [31:0] pc;
        logic [31:0] ir;
        bit          wen;
        int          cyc;
        logic [1:0]  cause;
        logic [15:0] ret;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_pc = RST_PC;
    logic [15:0] m_ret = '0;
    int          mem_mode = 0;     // 0 normal memory, 1 never acks, 2 random acks
    bit          illegal_next = 0;
    int          wb_seen = 0;
    logic [31:0] last_word = '0;

    function automatic logic [31:0] gen_word(input bit legal);
        logic [3:0]  ok_ops  [4]  = '{4'h0, 4'h8, 4'h2, 4'hA};
        logic [3:0]  bad_ops [12] = '{4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                                      4'h9, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
        logic [31:0] w;
        w = $urandom;
        if (legal) w[27:24] = ok_ops[$urandom_range(0, 3)];
        else       w[27:24] = bad_ops[$urandom_range(0, 11)];
        return w;
    endfunction

    // Instruction memory; every accepted fetch pushes its expected outcome
    initial begin : responder
        bit          waiting;
        bit          armed;
        bit          legal;
        int          dly;
        exp_t        e;
        logic [31:0] w;
        waiting = 0; armed = 1; dly = 0;
        forever begin
            @(posedge clk); #1;
            imem_ack = 1'b0;
            if (!imem_req) begin
                waiting = 0;
                armed   = 1;
            end
            case (mem_mode)
                0: begin
                    if (imem_req) begin
                        if (!waiting) begin
                            waiting = 1;
                            dly     = $urandom_range(0, 3);
                        end
                        if (dly == 0) begin
                            legal        = !illegal_next;
                            illegal_next = 0;
                            w            = gen_word(legal);
                            last_word    = w;
                            chk("fetch_addr", imem_addr, m_pc);
                            imem_ack   = 1'b1;
                            imem_rdata = w;
                            dec_wrtEn  = 1'($urandom_range(0, 1));
                            e.is_trap  = !legal;
                            e.pc       = m_pc;
                            e.ir       = w;
                            e.wen      = dec_wrtEn;
                            e.cause    = legal ? 2'd0 : 2'd1;
                            if (legal) begin
                                e.cyc = cyc + ALU_LAT + 2;
                                m_pc  = m_pc + 32'd4;
                                m_ret = m_ret + 16'd1;
                            end else begin
                                e.cyc = cyc + 2;
                            end
                            e.ret = m_ret;
                            sb.push_back(e);
                            waiting = 0;
                        end else begin
                            dly--;
                        end
                    end else if ($urandom_range(0, 7) == 0) begin
                        imem_ack   = 1'b1;
                        imem_rdata = $urandom;
                    end
                end
                1: begin
                    if (imem_req && armed) begin
                        armed = 0;
                        chk("timeout_fetch_addr", imem_addr, m_pc);
                        e.is_trap = 1;
                        e.pc      = m_pc;
                        e.ir      = '0;
                        e.wen     = 0;
                        e.cause   = 2'd2;
                        e.cyc     = cyc + TMO;
                        e.ret     = m_ret;
                        sb.push_back(e);
                    end
                end
                default: begin
                    imem_ack   = 1'($urandom_range(0, 1));
                    imem_rdata = $urandom;
                end
            endcase
        end
    end

    // Monitor: pops an expectation whenever the DUT writes back or traps
    initial begin : monitor
        bit   post;
        bit   exp_halt;
        bit   trap_prev;
        exp_t e;
        exp_t last;
        post = 0; exp_halt = 0; trap_prev = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                post      = 0;
                trap_prev = 0;
                continue;
            end
            if (post) begin
                post = 0;
                chk("post_wb_pc", pc, last.pc + 32'd4);
                chk("post_wb_retired", 32'(retired), 32'(last.ret));
                chk("post_wb_halted", 32'(halted), 32'(exp_halt));
                if (!exp_halt) chk("post_wb_state", 32'(state), 32'd1);
            end
            checks++;
            if (rf_wrtEn && state != 3'd4) begin
                errors++;
                $display("FAIL rf_wrtEn_outside_wb: got 1 in state %0d, expected 0", state);
            end
            if (state == 3'd2) chk("decode_imem_req", 32'(imem_req), 32'd0);
            if (state == 3'd4) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wb_unexpected: got WB at pc %0h, expected no event", pc);
                end else begin
                    e = sb.pop_front();
                    chk("wb_kind", 32'(e.is_trap), 32'd0);
                    chk("wb_pc", pc, e.pc);
                    chk("wb_ir", ir, e.ir);
                    chk("wb_rf_wrtEn", 32'(rf_wrtEn), 32'(e.wen));
                    chk("wb_cycle", cyc, e.cyc);
                    last     = e;
                    exp_halt = halt_req || !run;
                    post     = 1;
                    wb_seen++;
                end
            end
            if (trap && !trap_prev) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL trap_unexpected: got trap cause %0d, expected no event", trap_cause);
                end else begin
                    e = sb.pop_front();
                    chk("trap_kind", 32'(e.is_trap), 32'd1);
                    chk("trap_cause", 32'(trap_cause), 32'(e.cause));
                    chk("trap_pc", pc, e.pc);
                    chk("trap_retired", 32'(retired), 32'(e.ret));
                    chk("trap_cycle", cyc, e.cyc);
                    if (e.cause == 2'd1) chk("trap_ir", ir, e.ir);
                end
            end
            trap_prev = trap;
        end
    end

    task automatic do_reset();
        @(negedge clk); #1;
        rst_n    = 1'b0;
        run      = 1'b0;
        halt_req = 1'b0;
        sb.delete();
        m_pc  = RST_PC;
        m_ret = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : main
        bit found;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_pc", pc, RST_PC);
        chk("rst_ir", ir, 32'd0);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_rf_wrtEn", 32'(rf_wrtEn), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_trap", 32'(trap), 32'd0);
        chk("rst_trap_cause", 32'(trap_cause), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random run/halt traffic with legal instructions
        for (int i = 0; i < 3000 && wb_seen < 40; i++) begin
            @(posedge clk); #1;
            run      = ($urandom_range(0, 15) != 0);
            halt_req = ($urandom_range(0, 15) == 0);
        end
        chk("random_wb_progress", 32'(wb_seen >= 40), 32'd1);
        @(posedge clk); #1;
        run = 1'b0; halt_req = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (halted && sb.size() == 0) break;
        end
        chk("settle_halted", 32'(halted), 32'd1);
        chk("settle_queue_empty", 32'(sb.size()), 32'd0);

        // Illegal opcode trap, then the trap must ignore run and acks
        illegal_next = 1;
        @(posedge clk); #1;
        run = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (trap) break;
        end
        chk("illegal_trapped", 32'(trap), 32'd1);
        mem_mode = 2;
        repeat (20) begin
            @(posedge clk); #1;
            run      = 1'($urandom_range(0, 1));
            halt_req = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        chk("trap_hold_state", 32'(state), 32'd6);
        chk("trap_hold_pc", pc, m_pc);
        chk("trap_hold_retired", 32'(retired), 32'(m_ret));
        chk("trap_hold_cause", 32'(trap_cause), 32'd1);
        chk("trap_hold_ir", ir, last_word);
        chk("trap_hold_imem_req", 32'(imem_req), 32'd0);
        mem_mode = 0;
        do_reset();

        // Fetch timeout
        mem_mode = 1;
        @(posedge clk); #1;
        run = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (trap) break;
        end
        chk("timeout_trapped", 32'(trap), 32'd1);
        chk("timeout_cause", 32'(trap_cause), 32'd2);
        mem_mode = 0;
        do_reset();

        // Asynchronous reset in the middle of EXEC at pc 0x40
        @(posedge clk); #1;
        run = 1'b1; halt_req = 1'b0;
        found = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (state == 3'd3 && pc == 32'h40) begin
                found = 1;
                break;
            end
        end
        chk("exec_at_0x40_reached", 32'(found), 32'd1);
        #1 rst_n = 1'b0;
        sb.delete();
        m_pc  = RST_PC;
        m_ret = '0;
        run   = 1'b0;
        #1;
        chk("async_rst_state", 32'(state), 32'd0);
        chk("async_rst_pc", pc, RST_PC);
        chk("async_rst_ir", ir, 32'd0);
        chk("async_rst_rf_wrtEn", 32'(rf_wrtEn), 32'd0);
        chk("async_rst_retired", 32'(retired), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_rst_idle", 32'(state), 32'd0);

        for (int i = 0; i < 200 && !b_done; i++) @(negedge clk);
        chk("second_instance_done", 32'(b_done), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // One ALUR instruction at the top of memory: WB timing and PC wrap
    initial begin : bench_b
        int         req_cycles;
        int         pulses;
        int         pulse_cyc;
        int         t0;
        logic [2:0] pulse_state;
        req_cycles = 0; pulses = 0; pulse_cyc = -1; pulse_state = '0;
        #2 b_rst_n = 1'b0;
        #1;
        chk("b_rst_pc", b_pc, RST_PC_B);
        @(negedge clk);
        b_rst_n = 1'b1;
        @(posedge clk); #1;
        b_run = 1'b1;
        t0    = cyc;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b_rf_wrtEn) begin
                pulses++;
                pulse_cyc   = cyc;
                pulse_state = b_state;
            end
            @(posedge clk); #1;
            b_imem_ack = 1'b0;
            if (b_imem_req) begin
                if (req_cycles == 2) begin
                    chk("b_fetch_addr", b_imem_addr, RST_PC_B);
                    b_imem_ack   = 1'b1;
                    b_imem_rdata = 32'h0000_0123;
                    b_dec_wrtEn  = 1'b1;
                    b_run        = 1'b0;
                end
                req_cycles++;
            end
        end
        chk("b_wrtEn_pulses", 32'(pulses), 32'd1);
        chk("b_pulse_state", 32'(pulse_state), 32'd4);
        chk("b_wb_cycle", pulse_cyc, t0 + 6);
        chk("b_pc_wrapped", b_pc, 32'h0000_0000);
        chk("b_retired", 32'(b_retired), 32'd1);
        chk("b_ir", b_ir, 32'h0000_0123);
        chk("b_halted", 32'(b_halted), 32'd1);
        chk("b_no_trap", 32'(b_trap), 32'd0);
        b_done = 1;
    end

endmodule
`default_nettype wire
